dla_pulse_event_arbiter: RTL
============================

Name: dla_pulse_event_arbiter

Overview:
Destination-domain scheduler that collects single-cycle event pulses from NUM_CHANNELS independent clock-crossing pulse handshakes, all synchronised to clk_dst. It buffers them per channel in saturating pending counters. It serialises them onto one valid/ready event stream using round-robin arbitration, so one downstream consumer (CSR/interrupt logic) is shared fairly between all crossings without losing back-to-back events.

Parameters:
NUM_CHANNELS, 4, number of pulse inputs; legal range 2..32.
COUNT_WIDTH, 4, width of each pending counter; max pending per channel = 2^COUNT_WIDTH-1.
CHANNEL_WIDTH, $clog2(NUM_CHANNELS), width of o_channel; derived, do not override.

Ports:
clk_dst  in  1  destination clock; all logic on posedge.
i_dst_async_resetn  in  1  reset i_dst_async_resetn, asynchronous, active-low; deassertion synchronous to clk_dst.
i_dst_sync_resetn  in  1  synchronous active-low reset; same effect as async reset; tie high if unused.
i_pulse  in  NUM_CHANNELS  one-cycle event pulses, one bit per channel, synchronous to clk_dst.
o_valid  out  1  event available on o_channel.
i_ready  in  1  consumer accepts event when o_valid & i_ready.
o_channel  out  CHANNEL_WIDTH  index of channel whose event is presented.
o_overflow  out  NUM_CHANNELS  sticky per-channel flag: an event was dropped because the counter was saturated.
i_clear_overflow  in  NUM_CHANNELS  per-channel clear of o_overflow.
o_idle  out  1  all counters zero and o_valid low.

Behaviour:
- Reset (either reset asserted) forces: all counters 0, o_valid 0, o_channel 0, o_overflow all 0, RR pointer = NUM_CHANNELS-1, so channel 0 has first priority. o_idle = 1.
- Load condition: load = (!o_valid | i_ready) & (any counter != 0). Counters are sampled at the start of the cycle.
- Selection on load: pick the first channel c with counter[c] != 0, scanning from pointer+1 upward and wrapping modulo NUM_CHANNELS. Register o_channel <= c and o_valid <= 1. Set pointer <= c. Decrement counter[c].
- If !load and o_valid & i_ready: o_valid <= 0. If !load and !(o_valid & i_ready): o_valid and o_channel hold; they are stable while stalled.
- Counter update per channel: next = cnt + i_pulse[c] - dec[c].
- If cnt is max, i_pulse[c]=1 and dec[c]=0: counter stays at max and o_overflow[c] <= 1.
- A pulse coinciding with a decrement at max nets to max with no overflow.
- A pulse on a zero counter is not selectable in the same cycle.
- Latency: pulse in cycle t -> counter 1 at t+1 -> o_valid at t+2 when the output is empty. Best case throughput is one event per cycle with i_ready held high.
- Overflow: if set and clear occur in the same cycle on the same channel, set wins. Otherwise i_clear_overflow[c] clears the flag the next cycle.
- o_idle is combinational from registered state: ~o_valid & (all counters == 0).
- Reset mid-operation discards the presented event and all pending counts. No event is emitted until a new pulse arrives.
- Protocol: no combinational path from i_ready to o_valid or o_channel. All outputs come from registers except o_idle, which is derived from registers only.

Test Plan:
- Single event: reset, pulse ch2 at cycle 0 with i_ready=1 -> o_valid=1, o_channel=2 at cycle 2 for exactly 1 cycle; o_idle returns to 1 at cycle 3.
- Round-robin fairness:
  - Stimulus: pulse ch0..ch3 simultaneously three times on consecutive cycles, i_ready=1.
  - Required: 12 events in order 0,1,2,3,0,1,2,3,0,1,2,3, one per cycle, no gaps.
- Backpressure hold: pulses on ch1 and ch3, i_ready=0 for 5 cycles -> o_valid=1, o_channel=1 stable all 5 cycles; after i_ready=1, events 1 then 3, then o_valid=0.
- Saturation/overflow (COUNT_WIDTH=4):
  - Stimulus: i_ready=0, 17 pulses on ch0.
  - Required: 1 event in the output register, counter = 15 after the 16th pulse, 17th pulse sets o_overflow[0]=1. Releasing i_ready yields exactly 16 events.
  - Then i_clear_overflow[0] -> o_overflow[0]=0 next cycle. Repeat with clear and set in the same cycle -> flag stays 1.
- Reset mid-operation: 3 pending on ch2 with o_valid=1, assert i_dst_sync_resetn=0 for 1 cycle -> next cycle o_valid=0, o_idle=1, no ch2 events afterward. Repeat with the async reset asserted off-clock; state clears immediately.
- Simultaneous pulse/accept: counter ch1=1 presented and accepted while a new ch1 pulse arrives -> next cycle o_channel=1, o_valid=1 again; total events equal total pulses.

Source files
------------

// File: rtl/dla_pulse_event_arbiter.sv
// Collects per-channel event pulses into saturating pending counters and
// serialises them onto one valid/ready stream with round-robin arbitration.
module dla_pulse_event_arbiter #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNT_WIDTH   = 4,
  parameter int CHANNEL_WIDTH = $clog2(NUM_CHANNELS)
) (
  input  logic                     clk_dst,
  input  logic                     i_dst_async_resetn,
  input  logic                     i_dst_sync_resetn,
  input  logic [NUM_CHANNELS-1:0]  i_pulse,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [CHANNEL_WIDTH-1:0] o_channel,
  output logic [NUM_CHANNELS-1:0]  o_overflow,
  input  logic [NUM_CHANNELS-1:0]  i_clear_overflow,
  output logic                     o_idle
);

  // Handshake: an event transfers on a clk_dst edge where o_valid & i_ready;
  // o_valid/o_channel are registered and hold steady while stalled.

  localparam logic [COUNT_WIDTH-1:0]   CNT_MAX   = '1;
  localparam logic [CHANNEL_WIDTH-1:0] PTR_RESET = CHANNEL_WIDTH'(NUM_CHANNELS - 1);

  logic [COUNT_WIDTH-1:0]   cnt_q [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]   cnt_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  pending;
  logic [NUM_CHANNELS-1:0]  dec;
  logic [NUM_CHANNELS-1:0]  ovf_d;
  logic [CHANNEL_WIDTH-1:0] ptr_q;
  logic [CHANNEL_WIDTH-1:0] ptr_d;
  logic [CHANNEL_WIDTH-1:0] sel;
  logic [CHANNEL_WIDTH-1:0] channel_d;
  logic                     valid_d;
  logic                     load;

  function automatic logic [CHANNEL_WIDTH-1:0] rr_index(
    input logic [CHANNEL_WIDTH-1:0] base,
    input int                       offset
  );
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_CHANNELS) sum = sum - NUM_CHANNELS;
    return CHANNEL_WIDTH'(sum);
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pending[c] = (cnt_q[c] != '0);
    end
  end

  // Scan from the farthest offset down so the nearest pending channel after
  // the pointer is the one left in sel.
  always_comb begin
    sel = '0;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      if (pending[rr_index(ptr_q, i)]) sel = rr_index(ptr_q, i);
    end
  end

  assign load = (~o_valid | i_ready) & (|pending);

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      dec[c]   = load && (sel == CHANNEL_WIDTH'(c));
      cnt_d[c] = cnt_q[c];
      ovf_d[c] = o_overflow[c];
      if (i_clear_overflow[c]) ovf_d[c] = 1'b0;
      if (i_pulse[c] && !dec[c]) begin
        if (cnt_q[c] == CNT_MAX) ovf_d[c] = 1'b1;
        else                     cnt_d[c] = cnt_q[c] + COUNT_WIDTH'(1);
      end else if (!i_pulse[c] && dec[c]) begin
        cnt_d[c] = cnt_q[c] - COUNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    valid_d   = o_valid;
    channel_d = o_channel;
    ptr_d     = ptr_q;
    if (load) begin
      valid_d   = 1'b1;
      channel_d = sel;
      ptr_d     = sel;
    end else if (i_ready) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_dst or negedge i_dst_async_resetn) begin
    if (!i_dst_async_resetn) begin
      for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= '0;
      o_valid    <= 1'b0;
      o_channel  <= '0;
      o_overflow <= '0;
      ptr_q      <= PTR_RESET;
    end else if (!i_dst_sync_resetn) begin
      for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= '0;
      o_valid    <= 1'b0;
      o_channel  <= '0;
      o_overflow <= '0;
      ptr_q      <= PTR_RESET;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= cnt_d[c];
      o_valid    <= valid_d;
      o_channel  <= channel_d;
      o_overflow <= ovf_d;
      ptr_q      <= ptr_d;
    end
  end

  assign o_idle = ~o_valid & ~(|pending);

endmodule
